// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: buffers operand pairs, issues them one at a time to the
// GCD core, and presents tagged results downstream. Jobs with a zero operand
// are resolved here and never reach the core.
//
// state | meaning
// IDLE  | waiting for a poppable head entry with no result pending
// ISSUE | core_ld_o pulse cycle; operands already on core_a_o/core_b_o
// WAIT  | job in flight; waiting for core_done_i
module gcd_job_sequencer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [W-1:0]    in_a_i,
    input  logic [W-1:0]    in_b_i,
    output logic            core_ld_o,
    output logic [W-1:0]    core_a_o,
    output logic [W-1:0]    core_b_o,
    input  logic            core_ready_i,
    input  logic            core_done_i,
    input  logic [W-1:0]    core_result_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [W-1:0]    res_data_o,
    output logic [TAGW-1:0] res_tag_o,
    output logic [15:0]     jobs_done_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;

    logic [W-1:0]    fifo_a   [DEPTH];
    logic [W-1:0]    fifo_b   [DEPTH];
    logic [TAGW-1:0] fifo_tag [DEPTH];

    // Extra MSB on the pointers distinguishes full from empty.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [TAGW-1:0] tag_cnt;
    logic [TAGW-1:0] cur_tag;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop_ok;
    logic            pop;
    logic            head_zero;
    logic [W-1:0]    head_a;
    logic [W-1:0]    head_b;
    logic [TAGW-1:0] head_tag;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;

    assign head_a    = fifo_a[rd_ptr[AW-1:0]];
    assign head_b    = fifo_b[rd_ptr[AW-1:0]];
    assign head_tag  = fifo_tag[rd_ptr[AW-1:0]];
    assign head_zero = (head_a == '0) || (head_b == '0);

    // A pop needs an idle sequencer and a free result register; core jobs
    // additionally need the core to be ready, bypass jobs do not.
    assign pop_ok = (state == IDLE) && !empty && !res_valid_o;
    assign pop    = pop_ok && (head_zero || core_ready_i);

    // FIFO storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr[AW-1:0]]   <= in_a_i;
            fifo_b[wr_ptr[AW-1:0]]   <= in_b_i;
            fifo_tag[wr_ptr[AW-1:0]] <= tag_cnt;
        end
    end

    // FIFO pointers and push-order tag counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + (AW+1)'(1);
                tag_cnt <= tag_cnt + TAGW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Job sequencing FSM with registered core and result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            core_ld_o   <= 1'b0;
            core_a_o    <= '0;
            core_b_o    <= '0;
            cur_tag     <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_tag_o   <= '0;
            jobs_done_o <= '0;
        end else begin
            // Result handshake; no set below can coincide because every set
            // path requires res_valid_o to be low.
            if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
                jobs_done_o <= jobs_done_o + 16'd1;
            end

            case (state)
                IDLE: begin
                    core_ld_o <= 1'b0;
                    if (pop_ok) begin
                        if (head_zero) begin
                            res_data_o  <= head_a | head_b;
                            res_tag_o   <= head_tag;
                            res_valid_o <= 1'b1;
                        end else if (core_ready_i) begin
                            core_a_o  <= head_a;
                            core_b_o  <= head_b;
                            cur_tag   <= head_tag;
                            core_ld_o <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_ld_o <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (core_done_i) begin
                        res_data_o  <= core_result_i;
                        res_tag_o   <= cur_tag;
                        res_valid_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    core_ld_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Testbench for gcd_job_sequencer with a behavioural GCD core attached.
module tb_gcd_job_sequencer;

    logic        clk;
    logic        resetn;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_a_i;
    logic [15:0] in_b_i;
    logic        core_ld_o;
    logic [15:0] core_a_o;
    logic [15:0] core_b_o;
    logic        core_ready_i;
    logic        core_done_i;
    logic [15:0] core_result_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_data_o;
    logic [3:0]  res_tag_o;
    logic [15:0] jobs_done_o;

    int checks = 0;
    int errors = 0;

    gcd_job_sequencer #(.W(16), .DEPTH(4), .TAGW(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_a_i        (in_a_i),
        .in_b_i        (in_b_i),
        .core_ld_o     (core_ld_o),
        .core_a_o      (core_a_o),
        .core_b_o      (core_b_o),
        .core_ready_i  (core_ready_i),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .res_tag_o     (res_tag_o),
        .jobs_done_o   (jobs_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: accepts on ld, answers after core_lat + 1 cycles.
    logic        core_busy;
    logic        model_done;
    logic        stray_done;
    logic        core_ready_en;
    logic [15:0] cap_a;
    logic [15:0] cap_b;
    logic [15:0] model_res;
    int          core_cnt;
    int          core_lat = 2;
    int          ld_count = 0;

    assign core_ready_i  = !core_busy && core_ready_en;
    assign core_done_i   = model_done | stray_done;
    assign core_result_i = model_res;

    function automatic logic [15:0] gcd_f(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_busy  <= 1'b0;
            model_done <= 1'b0;
            model_res  <= 16'd0;
            cap_a      <= 16'd0;
            cap_b      <= 16'd0;
            core_cnt   <= 0;
        end else begin
            model_done <= 1'b0;
            if (core_ld_o && !core_busy) begin
                core_busy <= 1'b1;
                cap_a     <= core_a_o;
                cap_b     <= core_b_o;
                core_cnt  <= core_lat;
            end else if (core_busy) begin
                if (core_cnt == 0) begin
                    model_done <= 1'b1;
                    model_res  <= gcd_f(cap_a, cap_b);
                    core_busy  <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (resetn && core_ld_o) ld_count++;
    end

    // Operands must stay put for the whole time the core is working.
    always @(negedge clk) begin
        if (resetn && core_busy) begin
            check("hold_a", core_a_o, cap_a);
            check("hold_b", core_b_o, cap_b);
        end
    end

    task automatic apply_reset();
        resetn     = 1'b0;
        in_valid_i = 1'b0;
        res_ready_i = 1'b0;
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready_o,  1);
        check({tag, "_core_ld"},   core_ld_o,   0);
        check({tag, "_core_a"},    core_a_o,    0);
        check({tag, "_core_b"},    core_b_o,    0);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_res_data"},  res_data_o,  0);
        check({tag, "_res_tag"},   res_tag_o,   0);
        check({tag, "_jobs_done"}, jobs_done_o, 0);
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stuck low for a=%0d b=%0d", a, b);
        end else begin
            in_valid_i = 1'b1;
            in_a_i     = a;
            in_b_i     = b;
            @(posedge clk);
            #1 in_valid_i = 1'b0;
        end
    endtask

    task automatic get_result(input logic [15:0] exp_d, input logic [3:0] exp_t, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, res_valid_o, 1);
        if (res_valid_o) begin
            check({name, "_data"}, res_data_o, exp_d);
            check({name, "_tag"},  res_tag_o,  exp_t);
            res_ready_i = 1'b1;
            @(posedge clk);
            #1 res_ready_i = 1'b0;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_d;
        logic [3:0]  exp_t;
    } vec_t;

    vec_t vecs [28];

    task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] d, input logic [3:0] t);
        vecs[i].a     = a;
        vecs[i].b     = b;
        vecs[i].exp_d = d;
        vecs[i].exp_t = t;
    endtask

    initial begin
        int ld0;
        int n;
        logic [15:0] hold_d;
        logic [3:0]  hold_t;

        // Tag-wrap jobs a=3k, b=3: result 3, tags 0..15 then 0, 1.
        set_vec(0,  16'd3,  16'd3, 16'd3, 4'd0);
        set_vec(1,  16'd6,  16'd3, 16'd3, 4'd1);
        set_vec(2,  16'd9,  16'd3, 16'd3, 4'd2);
        set_vec(3,  16'd12, 16'd3, 16'd3, 4'd3);
        set_vec(4,  16'd15, 16'd3, 16'd3, 4'd4);
        set_vec(5,  16'd18, 16'd3, 16'd3, 4'd5);
        set_vec(6,  16'd21, 16'd3, 16'd3, 4'd6);
        set_vec(7,  16'd24, 16'd3, 16'd3, 4'd7);
        set_vec(8,  16'd27, 16'd3, 16'd3, 4'd8);
        set_vec(9,  16'd30, 16'd3, 16'd3, 4'd9);
        set_vec(10, 16'd33, 16'd3, 16'd3, 4'd10);
        set_vec(11, 16'd36, 16'd3, 16'd3, 4'd11);
        set_vec(12, 16'd39, 16'd3, 16'd3, 4'd12);
        set_vec(13, 16'd42, 16'd3, 16'd3, 4'd13);
        set_vec(14, 16'd45, 16'd3, 16'd3, 4'd14);
        set_vec(15, 16'd48, 16'd3, 16'd3, 4'd15);
        set_vec(16, 16'd51, 16'd3, 16'd3, 4'd0);
        set_vec(17, 16'd54, 16'd3, 16'd3, 4'd1);
        // Mixed operands, continuing the tag sequence.
        set_vec(18, 16'd48,    16'd18,    16'd6,     4'd2);
        set_vec(19, 16'd17,    16'd5,     16'd1,     4'd3);
        set_vec(20, 16'd65535, 16'd1,     16'd1,     4'd4);
        set_vec(21, 16'd1,     16'd65535, 16'd1,     4'd5);
        set_vec(22, 16'd0,     16'd7,     16'd7,     4'd6);
        set_vec(23, 16'd9,     16'd0,     16'd9,     4'd7);
        set_vec(24, 16'd100,   16'd100,   16'd100,   4'd8);
        set_vec(25, 16'd1024,  16'd768,   16'd256,   4'd9);
        set_vec(26, 16'd65535, 16'd65535, 16'd65535, 4'd10);
        set_vec(27, 16'd21,    16'd14,    16'd7,     4'd11);

        resetn        = 1'b0;
        in_valid_i    = 1'b0;
        in_a_i        = 16'd0;
        in_b_i        = 16'd0;
        res_ready_i   = 1'b0;
        stray_done    = 1'b0;
        core_ready_en = 1'b1;

        // Reset state.
        apply_reset();
        @(negedge clk);
        check_reset_values("reset");

        // Single core job with latency and pulse-width checks.
        ld0 = ld_count;
        push(16'd48, 16'd18);
        @(negedge clk);
        check("single_ld_before", core_ld_o, 0);
        @(negedge clk);
        check("single_ld_pulse", core_ld_o, 1);
        check("single_core_a", core_a_o, 48);
        check("single_core_b", core_b_o, 18);
        @(negedge clk);
        check("single_ld_after", core_ld_o, 0);
        get_result(16'd6, 4'd0, "single");
        @(negedge clk);
        check("single_ld_count", ld_count - ld0, 1);
        check("single_jobs_done", jobs_done_o, 1);
        check("single_valid_clear", res_valid_o, 0);

        // Zero bypass.
        apply_reset();
        ld0 = ld_count;
        push(16'd0, 16'd35);
        @(negedge clk);
        check("bypass_valid_early", res_valid_o, 0);
        @(negedge clk);
        check("bypass_valid_edge2", res_valid_o, 1);
        push(16'd0, 16'd0);
        get_result(16'd35, 4'd0, "bypass0");
        get_result(16'd0, 4'd1, "bypass1");
        @(negedge clk);
        check("bypass_no_ld", ld_count - ld0, 0);
        check("bypass_jobs_done", jobs_done_o, 2);

        // Core not ready: the head waits in IDLE.
        apply_reset();
        core_ready_en = 1'b0;
        ld0 = ld_count;
        push(16'd8, 16'd12);
        repeat (6) @(negedge clk);
        check("notready_no_ld", ld_count - ld0, 0);
        check("notready_valid", res_valid_o, 0);
        core_ready_en = 1'b1;
        get_result(16'd4, 4'd0, "notready");

        // Backpressure: one job completes, four fill the FIFO, sixth refused.
        apply_reset();
        push(16'd12, 16'd8);
        push(16'd10, 16'd4);
        push(16'd9,  16'd6);
        push(16'd14, 16'd21);
        push(16'd25, 16'd15);
        n = 0;
        @(negedge clk);
        while (!res_valid_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_first_valid", res_valid_o, 1);
        check("bp_first_data", res_data_o, 4);
        check("bp_first_tag", res_tag_o, 0);
        check("bp_full", in_ready_o, 0);
        hold_d = res_data_o;
        hold_t = res_tag_o;
        ld0 = ld_count;
        in_valid_i = 1'b1;
        in_a_i     = 16'd100;
        in_b_i     = 16'd75;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_ready_low", in_ready_o, 0);
            check("bp_data_stable", res_data_o, hold_d);
            check("bp_tag_stable", res_tag_o, hold_t);
        end
        in_valid_i = 1'b0;
        check("bp_no_ld", ld_count - ld0, 0);
        get_result(16'd4, 4'd0, "bp0");
        get_result(16'd2, 4'd1, "bp1");
        get_result(16'd3, 4'd2, "bp2");
        get_result(16'd7, 4'd3, "bp3");
        get_result(16'd5, 4'd4, "bp4");
        repeat (20) @(negedge clk);
        check("bp_no_extra", res_valid_o, 0);
        check("bp_jobs_done", jobs_done_o, 5);

        // Table: tag wrap then mixed operands.
        apply_reset();
        for (int i = 0; i < 28; i++) begin
            push(vecs[i].a, vecs[i].b);
            get_result(vecs[i].exp_d, vecs[i].exp_t, $sformatf("vec%0d", i));
            if (i == 17) begin
                @(negedge clk);
                check("wrap_jobs_done", jobs_done_o, 18);
            end
        end
        @(negedge clk);
        check("table_jobs_done", jobs_done_o, 28);

        // Reset during WAIT with two jobs queued.
        apply_reset();
        core_lat = 12;
        ld0 = ld_count;
        push(16'd30, 16'd12);
        push(16'd5,  16'd10);
        push(16'd6,  16'd9);
        repeat (2) @(negedge clk);
        check("rst_mid_in_flight", core_busy, 1);
        check("rst_mid_ld_seen", ld_count - ld0, 1);
        #2 resetn = 1'b0;
        #1 check_reset_values("rst_mid");
        @(negedge clk);
        resetn   = 1'b1;
        core_lat = 2;
        push(16'd7, 16'd21);
        get_result(16'd7, 4'd0, "rst_after");
        repeat (20) @(negedge clk);
        check("rst_queue_lost", res_valid_o, 0);
        check("rst_jobs_done", jobs_done_o, 1);

        // Stray done in IDLE with an empty FIFO.
        apply_reset();
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_valid", res_valid_o, 0);
        end
        check("stray_jobs_done", jobs_done_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_job_sequencer.md
# gcd_job_sequencer

Initiator-side sequencer for the team's GCD core: it buffers operand pairs from an upstream valid/ready stream and issues them one at a time to the core with a single-cycle `ld_i` pulse. It then waits for the core's `done`, captures the result with its job tag and presents it on a downstream valid/ready port. It sits between the system bus adapter and the GCD controller/datapath pair. It also resolves zero-operand jobs locally, which the core must never see.

## Interface
Parameters:
- `W`, 16: operand and result width.
- `DEPTH`, 4: input FIFO entries; a power of 2, ≥2.
- `TAGW`, 4: job tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid_i`  in  1  an operand pair is offered.
- `in_ready_o`  out  1  FIFO can accept (`!full`).
- `in_a_i`, `in_b_i`  in  W  operands.
- `core_ld_o`  out  1  drives the core `ld_i`; a one-cycle pulse.
- `core_a_o`, `core_b_o`  out  W  operands to the core, held from the `ld` cycle until `done`.
- `core_ready_i`  in  1  core `ready`.
- `core_done_i`  in  1  core `done`; a one-cycle pulse.
- `core_result_i`  in  W  core result, valid while `core_done_i`.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  downstream accepts the result.
- `res_data_o`  out  W  GCD result.
- `res_tag_o`  out  TAGW  tag of the job that produced the result.
- `jobs_done_o`  out  16  count of results accepted downstream; wraps at 2^16.

## Operation
- **Push:** on `in_valid_i && in_ready_o`, write `{a, b, tag_cnt}` to the FIFO and increment `tag_cnt` (wraps 2^TAGW−1 → 0). Tags are assigned in push order.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE, pop condition:** FIFO non-empty and `res_valid_o == 0`. When the condition holds:
  - If the head has `a == 0` or `b == 0`: pop and load the result register with `a | b` and the head's tag. Set `res_valid_o`; stay in IDLE; `core_ld_o` stays 0. This gives gcd(0,b)=b and gcd(0,0)=0.
  - Otherwise, if `core_ready_i`: pop, register the head into `core_a_o`/`core_b_o`/`cur_tag`, and go to ISSUE.
  - Otherwise, stay in IDLE.
- **ISSUE:** `core_ld_o = 1` for this cycle only. Go to WAIT unconditionally.
- **WAIT:** on `core_done_i`, capture `core_result_i` → `res_data_o` and `cur_tag` → `res_tag_o`, set `res_valid_o`, and go to IDLE. `core_a_o`/`core_b_o` hold their values throughout WAIT.
- **Result register:**
  - `res_valid_o` clears on `res_valid_o && res_ready_i`, and `jobs_done_o` increments on the same edge.
  - `res_data_o`/`res_tag_o` are stable while `res_valid_o && !res_ready_i`.
- **One job in flight:** at most one job is outstanding. A new job is never popped while `res_valid_o` is high, so a `done` can never overwrite an unconsumed result.
- **Unexpected done:** `core_done_i` outside WAIT is ignored.

## Timing
- **Reset values:**
  - `in_ready_o` = 1 (FIFO empty).
  - `core_ld_o`, `core_a_o`, `core_b_o`, `res_valid_o`, `res_data_o`, `res_tag_o`, `jobs_done_o` = 0.
  - FSM = IDLE, `tag_cnt` = 0, FIFO pointers = 0.
- **FIFO:** registered. An entry pushed at edge N is poppable at the earliest in the cycle after edge N; there is no fall-through.
- **Push/pop when full:** `in_ready_o` is strictly `!full`. A push is refused while full even if a pop occurs in the same cycle.
- **Push/pop when non-empty:** a simultaneous push and pop is allowed and the count is unchanged.
- **Latency, core path:** push edge N → pop edge N+1 (IDLE) → `core_ld_o` high in cycle N+2 (ISSUE). `res_valid_o` rises on the edge after the `core_done_i` cycle.
- **Latency, zero bypass:** push edge N → `res_valid_o` high after edge N+1.
- **Back-to-back results:**
  - Result accepted at edge M: the next pop can occur at edge M+1.
  - The minimum `res_valid_o` gap is 1 cycle for bypass jobs and 2 cycles plus the core latency for core jobs.
- **Reset mid-operation:** asserting `resetn` low clears all state immediately, including the FIFO contents, any in-flight job, and a pending result. The in-flight job is lost.

## Test plan
- **Single core job:** push (48,18) with the team GCD core attached → exactly one `core_ld_o` pulse with `core_a_o`=48, `core_b_o`=18 held until `done`. Then `res_data_o`=6, `res_tag_o`=0, and `jobs_done_o`=1 after acceptance.
- **Zero bypass:** push (0,35), then (0,0) → results 35 (tag 0) and 0 (tag 1). No `core_ld_o` is ever asserted. The first `res_valid_o` appears 2 edges after its push.
- **Backpressure:**
  - Hold `res_ready_i`=0 and push (12,8), then 5 more pairs. The first job completes with `res_data_o`=4, `res_tag_o`=0; the remaining 4 fill the FIFO, `in_ready_o` drops, and the 6th push is not accepted.
  - While `res_ready_i` is held low there is no further `core_ld_o`, and `res_data_o`/`res_tag_o` stay stable.
  - After releasing `res_ready_i`, results drain in push order.
- **Tag wrap and ordering:** push 18 jobs (a=3k, b=3, k=1..18) with `res_ready_i`=1 → all results are 3, tags run 0..15 then 0, 1, and `jobs_done_o`=18.
- **Reset mid-WAIT:** assert `resetn`=0 during WAIT with 2 jobs queued → all outputs read their reset values immediately. After release, push (7,21) → result 7 with tag 0.
- **Stray done:** pulse `core_done_i` while in IDLE with an empty FIFO → `res_valid_o` stays 0 and `jobs_done_o` is unchanged.
